// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor (diff = a - b), one bit per clock,
// LSB first, with a registered borrow and a start/done handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed `overflow` output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef SERIAL_SUB_OVF_EN
  logic a_sgn_q, a_sgn_d;
  logic b_sgn_q, b_sgn_d;
  logic ovf_q, ovf_d;
`endif

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;

  // Single full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic dbit;
    logic bout;
    dbit = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, dbit};
  endfunction

  assign {br_nxt, d_bit} = full_sub(a_sh_q[0], b_sh_q[0], br_q);
  assign res_shift       = {d_bit, res_q[WIDTH-1:1]};

  // Next-state and datapath update: accept in IDLE/DONE, one bit per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_sgn_d  = a_sgn_q;
    b_sgn_d  = b_sgn_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_sgn_d = a[WIDTH-1];
          b_sgn_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        br_d   = br_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Outputs change only here, so they hold across the next accept.
          diff_d   = res_shift;
          borrow_d = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // d_bit is the result MSB on the final step.
          ovf_d    = (a_sgn_q != b_sgn_q) && (d_bit != a_sgn_q);
`endif
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_q  <= a_sgn_d;
      b_sgn_q  <= b_sgn_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8), with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] held_diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete operation; optionally pulses an ignored start at RUN cycle poke_k.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o,
                        input int poke_k);
    a = av;
    b = bv;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      chk("diff_hold", diff, held_diff);
      if (k == poke_k) begin
        a = 8'h0F;
        b = 8'h01;
        start = 1'b1;
      end
      tick;
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("diff", diff, exp_d);
    chk("borrow", borrow, exp_b);
`ifdef SERIAL_SUB_OVF_EN
    chk("overflow", overflow, exp_o);
`else
    if (exp_o) begin end
`endif
    held_diff = exp_d;
    tick;
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("diff_after", diff, exp_d);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    held_diff = '0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    reset = 1'b0;
    tick;

    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, -1);
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("diff_idle_hold", diff, 8'hDD);
    end
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, -1);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, -1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, -1);

    // start during RUN must be ignored
    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 3);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("no_queued_done", done, 0);
      chk("no_queued_busy", busy, 0);
    end

    // reset during the 4th RUN cycle
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("mid_rst_ovf", overflow, 0);
`endif
    held_diff = '0;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("no_done_after_rst", done, 0);
    end
    run_op(8'h50, 8'h10, 8'h40, 1'b0, 1'b0, -1);

    // back-to-back with start held high: one result every W+1 cycles
    a = 8'h09;
    b = 8'h03;
    start = 1'b1;
    tick;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < W; k++) begin
        chk("b2b_busy", busy, 1);
        chk("b2b_done_early", done, 0);
        chk("b2b_hold", diff, held_diff);
        tick;
      end
      chk("b2b_done", done, 1);
      chk("b2b_diff", diff, 8'h06);
      chk("b2b_borrow", borrow, 0);
      held_diff = 8'h06;
      if (r == 2) start = 1'b0;
      tick;
    end
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_done", done, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
